// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble), one bit per clock.
// Start/ready/done handshake; a start carrying a non-decimal digit is rejected with err_tick.
module bcd_to_bin_seq #(
    parameter int OUTPUT_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [3:0]              bcd_in [3:0],
    output logic [OUTPUT_WIDTH-1:0] bin_out,
    output logic                    ready,
    output logic                    done_tick,
    output logic                    err_tick
);

    localparam int IW = $clog2(OUTPUT_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              bcd_shift_reg [3:0];
    logic [3:0]              bcd_shift_next [3:0];
    logic [3:0]              bcd_step [3:0];
    logic [OUTPUT_WIDTH-1:0] bin_shift_reg, bin_shift_next, bin_step;
    logic [OUTPUT_WIDTH-1:0] bin_out_reg, bin_out_next;
    logic [IW-1:0]           index_reg, index_next;
    logic                    err_reg, err_next;
    logic [3:0]              digit_ok;

    // One shift step of the whole chain: each digit takes its upper neighbour's LSB
    // as its new MSB, then digits >= 8 are corrected by subtracting 3.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] shifted;
            if (gi == 3) begin : g_top
                assign shifted = {1'b0, bcd_shift_reg[gi][3:1]};
            end else begin : g_low
                assign shifted = {bcd_shift_reg[gi+1][0], bcd_shift_reg[gi][3:1]};
            end
            assign bcd_step[gi] = (shifted >= 4'd8) ? (shifted - 4'd3) : shifted;
            assign digit_ok[gi] = (bcd_in[gi] <= 4'd9);
        end
    endgenerate

    assign bin_step = {bcd_shift_reg[0][0], bin_shift_reg[OUTPUT_WIDTH-1:1]};

    always_comb begin
        state_next     = state_reg;
        bcd_shift_next = bcd_shift_reg;
        bin_shift_next = bin_shift_reg;
        bin_out_next   = bin_out_reg;
        index_next     = index_reg;
        err_next       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (&digit_ok) begin
                        bcd_shift_next = bcd_in;
                        bin_shift_next = '0;
                        index_next     = IW'(OUTPUT_WIDTH - 1);
                        state_next     = S_CONVERT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CONVERT: begin
                bcd_shift_next = bcd_step;
                bin_shift_next = bin_step;
                if (index_reg == '0) begin
                    bin_out_next = bin_step;
                    state_next   = S_DONE;
                end else begin
                    index_next = index_reg - IW'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                bcd_shift_reg[i] <= '0;
            end
            bin_shift_reg <= '0;
            bin_out_reg   <= '0;
            index_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bcd_shift_reg <= bcd_shift_next;
            bin_shift_reg <= bin_shift_next;
            bin_out_reg   <= bin_out_next;
            index_reg     <= index_next;
            err_reg       <= err_next;
        end
    end

    assign bin_out   = bin_out_reg;
    assign ready     = (state_reg == S_IDLE);
    assign done_tick = (state_reg == S_DONE);
    assign err_tick  = err_reg;

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter using the reverse double-dabble (shift-right / subtract-3) algorithm, one bit per clock. It is the inverse of the team's binary-to-BCD output stage. It turns a 4-digit decimal value entered from switches or a keypad into a binary operand (e.g. `n` for the difference engines). A start/ready/done handshake lets it sit between an input debouncer and any FSMD consumer.

## Interface
- `OUTPUT_WIDTH`, default 14: binary result width. Must be ≥ 14 so that 9999 fits. The conversion takes exactly `OUTPUT_WIDTH` shift cycles.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input, 1 bit: request a conversion. Sampled only while `ready` = 1.
- `bcd_in` input, `[3:0] bcd_in [3:0]`: four BCD digits. `bcd_in[3]` is thousands, `bcd_in[0]` is units. Sampled only on an accepted `start`.
- `bin_out` output, `OUTPUT_WIDTH` bits: registered result. Holds its value until the next successful conversion completes.
- `ready` output, 1 bit: high only in the idle state.
- `done_tick` output, 1 bit: one-cycle pulse. `bin_out` is valid and new in that cycle.
- `err_tick` output, 1 bit: one-cycle pulse. Signals that a `start` was rejected because some digit was greater than 9.

## Operation
- **Registers:** `state_reg`, `bcd_shift_reg[3:0]` (4×4 bits), `bin_shift_reg` (`OUTPUT_WIDTH` bits), `index_reg` (width `$clog2(OUTPUT_WIDTH+1)`), `bin_out_reg`, `err_reg`.
- **Reset** (`reset_n` low at an edge): state → `idle`; all registers cleared. Outputs after reset: `bin_out` = 0, `ready` = 1, `done_tick` = 0, `err_tick` = 0. Reset overrides everything, including a conversion in progress; no `done_tick` is produced for an aborted conversion.
- **States:** `idle`, `convert`, `done`.
- **`idle`:** `ready` = 1.
  - `start` with every digit ≤ 9: load `bcd_shift_reg` ← `bcd_in`, `bin_shift_reg` ← 0, `index_reg` ← `OUTPUT_WIDTH`−1, then go to `convert`.
  - `start` with any digit > 9: set `err_tick` for the next cycle and stay in `idle`. No register other than `err_reg` changes.
  - No `start`: remain in `idle`.
- **`convert`:** each cycle does one shift step, in this order:
  1. Shift the 16-bit BCD chain and the binary register right as one unit: `bin_shift_next` = {`bcd_shift_reg[0][0]`, `bin_shift_reg[OUTPUT_WIDTH-1:1]`}.
  2. Each digit `i` < 3 takes `bcd_shift_reg[i+1][0]` as its new MSB. Digit 3 takes 0.
  3. Correct each shifted digit: if the digit is ≥ 8, subtract 3 (4-bit, no borrow out). Otherwise leave it unchanged.
  - Then test the counter:
    - `index_reg` = 0: load `bin_out_reg` ← `bin_shift_next` and go to `done`.
    - Otherwise: `index_reg` decrements.
- **`done`:** `done_tick` = 1 and `ready` = 0; go to `idle` unconditionally. `start` is ignored in this state.
- **`start` while busy:** ignored in `convert` and `done`. It is not queued.
- **Arithmetic:** every input of 0000–9999 converts exactly. After the last shift the BCD chain is all zeros. Because digits are validated before loading, no correction ever underflows.

## Timing
- `start` accepted at edge T: `ready` falls at T+1.
- `convert` occupies the `OUTPUT_WIDTH` cycles from T+1 (14 cycles for the default).
- `done` is cycle T+1+`OUTPUT_WIDTH`, which is T+15 for the default. In that cycle `done_tick` = 1 and `bin_out` holds the new value.
- `ready` returns at T+16 (default). The earliest back-to-back `start` is accepted at that edge, giving a throughput of one conversion per 16 cycles.
- A rejected `start` at edge T: `err_tick` is high during T+1 only. `ready` stays 1 throughout, so a valid `start` in T+1 is accepted normally.
- `bin_out` changes only at the edge entering `done` or on reset. It does not change during `convert`.
- All outputs are registered or decoded from `state_reg`; there is no combinational path from input to output.

## Test plan
- **Reset and zero:** hold `reset_n` low for 2 cycles, release, then `start` with `bcd_in` = {0,0,0,0}. Expect `bin_out` = 0 and `ready` = 1 after reset. Expect `done_tick` exactly 15 cycles after the `start` edge with `bin_out` = 0.
- **Known values:** 1234 → 0x04D2. 9999 → 0x270F. 0001 → 1. 0800 → 0x0320. Each gives exactly one `done_tick` and `ready` low for exactly 15 cycles.
- **Invalid digit:** `start` with {0,0xA,0,0} → `err_tick` for one cycle, no `done_tick`, `bin_out` keeps its previous value, `ready` stays 1. A valid `start` in the next cycle converts normally.
- **Busy rejection:** `start` with 1234, then pulse `start` with 5678 at cycles 3 and 14 of `convert`. Expect a single `done_tick` with 0x04D2 and no second conversion.
- **Reset mid-operation:** drive `reset_n` low in the 7th `convert` cycle. Expect `bin_out` = 0, `ready` = 1 and no `done_tick`. A later conversion of 0042 → 0x002A succeeds.
- **Back-to-back:** 0099 followed by 9990 with `start` held high continuously. Expect `done_tick` at T+15 (`bin_out` = 0x0063) and at T+31 (`bin_out` = 0x2706).
